text_console_ctrl: RTL and testbench

Write-side controller for the 64x32-cell colour character buffer used by the text display. It accepts a stream of characters on a valid/ready handshake and keeps a cursor. Printable characters become single-cycle writes on the buffer's write port; control codes are interpreted. At the bottom row it scrolls by bumping a row offset the display side adds to its row index, then clearing the newly exposed row. Sits between any text source (UART, test pattern, CPU) and the buffer's write port, in the pixel clock domain.

---
 rtl/text_console_ctrl.sv | 172 +++++++++++++++++
 tb/tb_text_console_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
// Write-side controller for the 64x32 colour character buffer: accepts a character
// stream, keeps a cursor, interprets control codes and scrolls via a row offset.
module text_console_ctrl #(
  parameter int          COLS         = 60,
  parameter int          ROWS         = 17,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h07,
  parameter logic [7:0]  CLEAR_CHAR   = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_char,
  input  logic [7:0]  i_attr,
  output logic        o_ready,
  output logic [10:0] o_ada,
  output logic [15:0] o_din,
  output logic        o_cea,
  output logic [4:0]  o_row_offset,
  output logic [5:0]  o_cursor_x,
  output logic [4:0]  o_cursor_y,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_t;

  localparam logic [15:0] CLEAR_WORD = {DEFAULT_ATTR, CLEAR_CHAR};
  localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [4:0]  ROWS_MOD   = 5'(ROWS % 32);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [5:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic [4:0]  off_q, off_d;
  logic [4:0]  row_q, row_d;
  logic        cea_q, cea_d;
  logic [10:0] ada_q, ada_d;
  logic [15:0] din_q, din_d;
  logic        newline;
  logic [4:0]  phys_row;

  assign phys_row = cy_q + off_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR_ALL;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      off_q   <= '0;
      row_q   <= '0;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      off_q   <= off_d;
      row_q   <= row_d;
      cea_q   <= cea_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
    end
  end

  // Clear counters run one step past the last write so that ready/busy change
  // only in the cycle after the final registered write is visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    off_d   = off_q;
    row_d   = row_q;
    cea_d   = 1'b0;
    ada_d   = '0;
    din_d   = '0;
    newline = 1'b0;

    case (state_q)
      CLEAR_ALL: begin
        if (cnt_q == 12'd2048) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cea_d = 1'b1;
          ada_d = cnt_q[10:0];
          din_d = CLEAR_WORD;
          cnt_d = cnt_q + 12'd1;
        end
      end

      CLEAR_LINE: begin
        if (cnt_q == 12'd64) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cea_d = 1'b1;
          ada_d = {row_q, cnt_q[5:0]};
          din_d = CLEAR_WORD;
          cnt_d = cnt_q + 12'd1;
        end
      end

      IDLE: begin
        if (i_valid) begin
          case (i_char)
            CH_LF: newline = 1'b1;
            CH_CR: cx_d = '0;
            CH_BS: begin
              if (cx_q != '0) cx_d = cx_q - 6'd1;
            end
            CH_FF: begin
              cx_d    = '0;
              cy_d    = '0;
              off_d   = '0;
              cnt_d   = '0;
              state_d = CLEAR_ALL;
            end
            default: begin
              cea_d = 1'b1;
              ada_d = {phys_row, cx_q};
              din_d = {i_attr, i_char};
              if (cx_q < LAST_COL) cx_d = cx_q + 6'd1;
              else                 newline = 1'b1;
            end
          endcase

          if (newline) begin
            cx_d = '0;
            if (cy_q < LAST_ROW) begin
              cy_d = cy_q + 5'd1;
            end else begin
              // Newly exposed row is (new offset + ROWS-1) = old offset + ROWS.
              off_d   = off_q + 5'd1;
              row_d   = off_q + ROWS_MOD;
              cnt_d   = '0;
              state_d = CLEAR_LINE;
            end
          end
        end
      end

      default: begin
        state_d = CLEAR_ALL;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_ready      = (state_q == IDLE) & ~i_rst;
  assign o_busy       = (state_q != IDLE) | i_rst;
  assign o_cea        = cea_q & ~i_rst;
  assign o_ada        = i_rst ? '0 : ada_q;
  assign o_din        = i_rst ? '0 : din_q;
  assign o_cursor_x   = i_rst ? '0 : cx_q;
  assign o_cursor_y   = i_rst ? '0 : cy_q;
  assign o_row_offset = i_rst ? '0 : off_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: reset clear, streaming, wrap, control codes,
// scrolling, form feed and reset during a line clear.
module tb_text_console_ctrl;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  ch;
  logic [7:0]  attr;
  logic        ready;
  logic [10:0] ada;
  logic [15:0] din;
  logic        cea;
  logic [4:0]  row_offset;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  text_console_ctrl #(
    .COLS(60),
    .ROWS(17),
    .DEFAULT_ATTR(8'h07),
    .CLEAR_CHAR(8'h20)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(valid),
    .i_char(ch),
    .i_attr(attr),
    .o_ready(ready),
    .o_ada(ada),
    .o_din(din),
    .o_cea(cea),
    .o_row_offset(row_offset),
    .o_cursor_x(cursor_x),
    .o_cursor_y(cursor_y),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cursor(input string tag, input logic [5:0] x, input logic [4:0] y,
                            input logic [4:0] off);
    chk({tag, "_x"}, 32'(cursor_x), 32'(x));
    chk({tag, "_y"}, 32'(cursor_y), 32'(y));
    chk({tag, "_off"}, 32'(row_offset), 32'(off));
  endtask

  // Presents one character for one cycle; returns at the cycle after acceptance.
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    chk("ready_before_send", 32'(ready), 32'd1);
    valid = 1'b1;
    ch    = c;
    attr  = a;
    tick();
    valid = 1'b0;
  endtask

  // Called when the first full-buffer clear write should be visible.
  task automatic clear_all_seq(input string tag);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < 2048; i++) begin
      if (!(cea === 1'b1 && ada === 11'(i) && din === 16'h0720 &&
            ready === 1'b0 && busy === 1'b1)) bad++;
      tick();
    end
    chk({tag, "_bad_writes"}, bad, 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_cea_after"}, 32'(cea), 32'd0);
  endtask

  // Called when the first line-clear write (col 0) should be visible.
  task automatic clear_line_seq(input string tag, input logic [10:0] base);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (!(cea === 1'b1 && ada === base + 11'(i) && din === 16'h0720 &&
            ready === 1'b0 && busy === 1'b1)) bad++;
      tick();
    end
    chk({tag, "_bad_writes"}, bad, 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_cea_after"}, 32'(cea), 32'd0);
  endtask

  initial begin
    int unsigned bad;
    rst   = 1'b1;
    valid = 1'b0;
    ch    = 8'h00;
    attr  = 8'h00;

    // Reset state
    tick();
    tick();
    tick();
    chk("rst_cea", 32'(cea), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ada", 32'(ada), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk_cursor("rst", 6'd0, 5'd0, 5'd0);

    // Full clear after reset release
    rst = 1'b0;
    tick();
    clear_all_seq("reset_clear");
    chk_cursor("after_reset_clear", 6'd0, 5'd0, 5'd0);

    // Streaming: 'A','B' back to back
    valid = 1'b1;
    ch    = 8'h41;
    attr  = 8'h1F;
    tick();
    chk("stream_a_cea", 32'(cea), 32'd1);
    chk("stream_a_ada", 32'(ada), 32'h000);
    chk("stream_a_din", 32'(din), 32'h1F41);
    chk("stream_ready_mid", 32'(ready), 32'd1);
    ch = 8'h42;
    tick();
    valid = 1'b0;
    chk("stream_b_cea", 32'(cea), 32'd1);
    chk("stream_b_ada", 32'(ada), 32'h001);
    chk("stream_b_din", 32'(din), 32'h1F42);
    chk_cursor("stream", 6'd2, 5'd0, 5'd0);

    // CR returns to column 0 without writing
    send(8'h0D, 8'h00);
    chk("cr_no_write", 32'(cea), 32'd0);
    chk_cursor("cr", 6'd0, 5'd0, 5'd0);

    // Line wrap: 60 printable characters streamed from (0,0)
    bad   = 0;
    attr  = 8'h2A;
    valid = 1'b1;
    for (int unsigned i = 0; i < 60; i++) begin
      ch = 8'h30 + 8'(i);
      if (ready !== 1'b1) bad++;
      tick();
      if (!(cea === 1'b1 && ada === 11'(i) && din === {8'h2A, 8'h30 + 8'(i)})) bad++;
    end
    valid = 1'b0;
    chk("wrap_bad", bad, 32'd0);
    chk("wrap_last_ada", 32'(ada), 32'h03B);
    chk_cursor("wrap", 6'd0, 5'd1, 5'd0);
    tick();
    chk("wrap_no_clear", 32'(cea), 32'd0);
    chk("wrap_ready", 32'(ready), 32'd1);

    // Move to (5,3): two LFs and five characters on physical row 3
    send(8'h0A, 8'h00);
    chk("lf1_no_write", 32'(cea), 32'd0);
    send(8'h0A, 8'h00);
    chk_cursor("lf2", 6'd0, 5'd3, 5'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      send(8'h61 + 8'(i), 8'h4C);
      chk("row3_ada", 32'(ada), 32'h0C0 + i);
    end
    chk_cursor("at_5_3", 6'd5, 5'd3, 5'd0);

    // Control codes: BS, BS, CR, BS
    send(8'h08, 8'h00);
    chk("bs1_no_write", 32'(cea), 32'd0);
    chk_cursor("bs1", 6'd4, 5'd3, 5'd0);
    send(8'h08, 8'h00);
    chk_cursor("bs2", 6'd3, 5'd3, 5'd0);
    send(8'h0D, 8'h00);
    chk_cursor("cr2", 6'd0, 5'd3, 5'd0);
    send(8'h08, 8'h00);
    chk("bs3_no_write", 32'(cea), 32'd0);
    chk_cursor("bs3", 6'd0, 5'd3, 5'd0);

    // LFs down to the last row, then one more to scroll
    bad = 0;
    for (int unsigned i = 0; i < 13; i++) begin
      send(8'h0A, 8'h00);
      if (cea !== 1'b0) bad++;
    end
    chk("lf_run_no_writes", bad, 32'd0);
    chk_cursor("bottom", 6'd0, 5'd16, 5'd0);
    send(8'h0A, 8'h00);
    chk("scroll_entry_cea", 32'(cea), 32'd0);
    chk("scroll_entry_ready", 32'(ready), 32'd0);
    chk("scroll_entry_busy", 32'(busy), 32'd1);
    chk_cursor("scroll", 6'd0, 5'd16, 5'd1);
    tick();
    clear_line_seq("scroll1", 11'h440);
    chk_cursor("scroll1_done", 6'd0, 5'd16, 5'd1);

    // Printable at the bottom-right corner: write, then scroll
    bad   = 0;
    attr  = 8'h33;
    ch    = 8'h78;
    valid = 1'b1;
    for (int unsigned i = 0; i < 59; i++) begin
      tick();
      if (!(cea === 1'b1 && ada === 11'h440 + 11'(i))) bad++;
    end
    valid = 1'b0;
    chk("row16_fill_bad", bad, 32'd0);
    chk_cursor("corner", 6'd59, 5'd16, 5'd1);
    send(8'h5A, 8'h2E);
    chk("corner_cea", 32'(cea), 32'd1);
    chk("corner_ada", 32'(ada), 32'h47B);
    chk("corner_din", 32'(din), 32'h2E5A);
    chk("corner_ready", 32'(ready), 32'd0);
    chk_cursor("corner_scroll", 6'd0, 5'd16, 5'd2);
    tick();
    clear_line_seq("scroll2", 11'h480);

    // Held valid during a clear is ignored until ready returns
    send(8'h0A, 8'h00);
    chk_cursor("scroll3", 6'd0, 5'd16, 5'd3);
    valid = 1'b1;
    ch    = 8'h51;
    attr  = 8'h11;
    tick();
    clear_line_seq("scroll3", 11'h4C0);
    chk_cursor("held_not_taken", 6'd0, 5'd16, 5'd3);
    tick();
    valid = 1'b0;
    chk("held_write_ada", 32'(ada), 32'h4C0);
    chk("held_write_din", 32'(din), 32'h1151);
    chk_cursor("held_taken", 6'd1, 5'd16, 5'd3);

    // Form feed with offset 3
    send(8'h0C, 8'h00);
    chk("ff_no_write", 32'(cea), 32'd0);
    chk("ff_busy", 32'(busy), 32'd1);
    chk("ff_ready", 32'(ready), 32'd0);
    chk_cursor("ff", 6'd0, 5'd0, 5'd0);
    tick();
    clear_all_seq("ff_clear");

    // Reset at clear write 30 of a line clear
    bad = 0;
    for (int unsigned i = 0; i < 16; i++) send(8'h0A, 8'h00);
    chk_cursor("pre_abort", 6'd0, 5'd16, 5'd0);
    send(8'h0A, 8'h00);
    tick();
    for (int unsigned i = 0; i < 30; i++) begin
      if (!(cea === 1'b1 && ada === 11'h440 + 11'(i))) bad++;
      tick();
    end
    chk("abort_pre_bad", bad, 32'd0);
    chk("abort_write30_ada", 32'(ada), 32'h45E);
    rst = 1'b1;
    tick();
    chk("abort_rst_cea", 32'(cea), 32'd0);
    chk("abort_rst_busy", 32'(busy), 32'd1);
    chk("abort_rst_ready", 32'(ready), 32'd0);
    chk_cursor("abort_rst", 6'd0, 5'd0, 5'd0);
    rst = 1'b0;
    tick();
    clear_all_seq("abort_clear");
    chk_cursor("final", 6'd0, 5'd0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
